matrix_operand_loader: RTL and testbench
========================================

# matrix_operand_loader

Byte-serial front end for the 2x2 matrix ALU. Accepts one opcode byte followed by eight 8-bit matrix elements over a valid/ready byte stream, assembles them into the two 2x2 operand matrices, and holds them stable with a one-hot op select until the downstream ALU/capture stage acknowledges. It sits directly upstream of the combinational add/sub/mult matrix ALU, driving its a00..a11, b00..b11 and op inputs.

## Interface

- TIMEOUT, 255: max idle cycles between accepted element bytes while loading; 0 disables the timeout.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  8  stream byte (opcode or element).
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte.
- a00, a01, a10, a11  output  8 each  matrix A elements.
- b00, b01, b10, b11  output  8 each  matrix B elements.
- op  output  3  op select to ALU: bit0 add, bit1 sub, bit2 mult.
- mat_valid  output  1  operands and op are complete and stable.
- mat_ready  input  1  downstream has consumed the operand set.
- err  output  1  one-cycle pulse on a discarded frame.
- frame_cnt  output  8  count of completed handshakes, wraps 255->0.

## Operation

- A byte transfers on a rising edge where in_valid && in_ready.
- Frame order: op byte, then a00, a01, a10, a11, b00, b01, b10, b11 (9 bytes total).
- Op byte: in_data[2:0] latched into op; in_data[7:3] ignored.
- States:
  - IDLE: in_ready=1, mat_valid=0. On transfer, latch op and go to LOAD with element index 0.
  - LOAD: in_ready=1. Each transfer writes the element at the current index (0..7) and increments the index. The transfer at index 7 goes to HOLD.
  - HOLD: in_ready=0, mat_valid=1. All element and op outputs are frozen. When mat_ready=1, increment frame_cnt and go to IDLE.
- Element registers are written as bytes arrive. Outputs are meaningful only while mat_valid=1.
- Timeout, when TIMEOUT>0:
  - An idle counter clears on every transfer and on entry to LOAD.
  - It increments on each LOAD cycle with no transfer.
  - When it reaches TIMEOUT: pulse err, return to IDLE, discard the partial frame. frame_cnt is unchanged.
- The timeout does not apply in IDLE or HOLD. HOLD waits indefinitely.
- in_valid is ignored in HOLD because in_ready=0.
- mat_ready outside HOLD has no effect.

## Timing

- Reset values: in_ready=0 while rst_n=0 and 1 from the first edge after release (IDLE); mat_valid=0; err=0; op=0; all aij/bij=0; frame_cnt=0; state IDLE; index 0; idle counter 0.
- Last element (b11) accepted at edge N: mat_valid=1 and in_ready=0 from edge N to edge N+1 onward.
- Minimum frame: 9 transfer cycles, then mat_valid is visible in the following cycle.
- mat_ready sampled high at edge M in HOLD: mat_valid=0 and in_ready=1 after M. There is a one-cycle bubble; no byte is accepted in the cycle where mat_valid=1.
- err is high for exactly one cycle, the cycle after the discarding edge.
- Timeout fires on the TIMEOUT-th consecutive non-transfer LOAD cycle. A transfer on that same edge wins: it is accepted and the counter clears.
- Reset asserted mid-LOAD or in HOLD: all state returns to reset values immediately, with no err pulse.
- frame_cnt increments in the same edge as the HOLD exit and wraps 255 to 0.

## Configuration

- MATLOAD_OPCHECK_EN defined:
  - An op byte whose [2:0] is not one-hot (000, 011, 101, 110, 111) is consumed, pulses err, and the loader stays in IDLE.
  - op is not updated by a rejected byte.
- MATLOAD_OPCHECK_EN undefined:
  - Any [2:0] is accepted and passed straight to op.
  - The ALU then ORs the selected results.

## Test plan

- Reset then a back-to-back frame 0x01,1,2,3,4,5,6,7,8 with mat_ready=0 -> mat_valid=1 one cycle after b11, a00..b11=1..8, op=001, in_ready=0. Hold mat_ready=0 for 20 cycles -> outputs unchanged, no err.
- In HOLD, assert mat_ready for one cycle -> frame_cnt=1, mat_valid=0 and in_ready=1 next cycle. Send a second frame op 0x04 -> op=100.
- TIMEOUT=4: send op plus 3 elements, then in_valid=0 -> err pulses one cycle after the 4th idle LOAD cycle, state IDLE, frame_cnt unchanged. A subsequent full frame loads correctly.
- With MATLOAD_OPCHECK_EN, op byte 0x03 -> err pulse, op remains at its prior value, the next byte is treated as an op byte. Without the macro, the same byte -> op=011 and loading proceeds.
- Assert rst_n=0 after 5 elements of a frame -> all outputs reset, no err. After release a full frame completes normally.
- Complete 256 frames -> frame_cnt wraps to 0 on the 256th handshake.

Source files
------------

// File: rtl/matrix_operand_loader_if.sv
// Byte-stream and operand-set signals between the stream source, the loader
// and the downstream 2x2 matrix ALU/capture stage.
interface matrix_operand_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a00, a01, a10, a11;
   logic [7:0] b00, b01, b10, b11;
   logic [2:0] op;
   logic       mat_valid;
   logic       mat_ready;
   logic       err;
   logic [7:0] frame_cnt;

   modport master (
      output in_data, in_valid, mat_ready,
      input  in_ready, a00, a01, a10, a11, b00, b01, b10, b11,
      input  op, mat_valid, err, frame_cnt
   );

   modport slave (
      input  in_data, in_valid, mat_ready,
      output in_ready, a00, a01, a10, a11, b00, b01, b10, b11,
      output op, mat_valid, err, frame_cnt
   );
endinterface

// File: rtl/matrix_operand_loader.sv
// Assembles an opcode byte plus eight element bytes into two 2x2 operand matrices.
// Optional MATLOAD_OPCHECK_EN: reject op bytes whose [2:0] is not one-hot.
module matrix_operand_loader #(
   parameter int TIMEOUT = 255
) (
   input logic                     clk,
   input logic                     rst_n,
   matrix_operand_loader_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   state_t         state_r;
   logic [2:0]     idx_r;
   logic [CW-1:0]  idle_r;
   logic [7:0]     elem_r [0:7];
   logic [2:0]     op_r;
   logic           in_ready_r;
   logic           mat_valid_r;
   logic           err_r;
   logic [7:0]     frame_cnt_r;
   logic           xfer_s;

   function automatic logic is_onehot3(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

   assign xfer_s = bus.in_valid & in_ready_r;

   // Frame sequencing, element capture, idle timeout and handshake counting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         idx_r       <= 3'd0;
         idle_r      <= '0;
         op_r        <= 3'd0;
         in_ready_r  <= 1'b0;
         mat_valid_r <= 1'b0;
         err_r       <= 1'b0;
         frame_cnt_r <= 8'd0;
         for (int i = 0; i < 8; i++) begin
            elem_r[i] <= 8'd0;
         end
      end else begin
         err_r <= 1'b0;
         case (state_r)
            IDLE: begin
               in_ready_r  <= 1'b1;
               mat_valid_r <= 1'b0;
               if (xfer_s) begin
`ifdef MATLOAD_OPCHECK_EN
                  if (is_onehot3(bus.in_data[2:0])) begin
                     op_r    <= bus.in_data[2:0];
                     state_r <= LOAD;
                     idx_r   <= 3'd0;
                     idle_r  <= '0;
                  end else begin
                     err_r   <= 1'b1;
                  end
`else
                  op_r    <= bus.in_data[2:0];
                  state_r <= LOAD;
                  idx_r   <= 3'd0;
                  idle_r  <= '0;
`endif
               end
            end
            LOAD: begin
               if (xfer_s) begin
                  elem_r[idx_r] <= bus.in_data;
                  idx_r         <= idx_r + 3'd1;
                  idle_r        <= '0;
                  if (idx_r == 3'd7) begin
                     state_r     <= HOLD;
                     in_ready_r  <= 1'b0;
                     mat_valid_r <= 1'b1;
                  end
               end else if ((TIMEOUT != 0) && (idle_r == TO_LAST)) begin
                  // Partial frame dropped; element registers keep stale bytes.
                  err_r   <= 1'b1;
                  state_r <= IDLE;
                  idx_r   <= 3'd0;
                  idle_r  <= '0;
               end else if (TIMEOUT != 0) begin
                  idle_r <= idle_r + CW'(1);
               end
            end
            HOLD: begin
               if (bus.mat_ready) begin
                  state_r     <= IDLE;
                  mat_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  frame_cnt_r <= frame_cnt_r + 8'd1;
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b0;
               mat_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.mat_valid = mat_valid_r;
   assign bus.err       = err_r;
   assign bus.op        = op_r;
   assign bus.frame_cnt = frame_cnt_r;
   assign bus.a00       = elem_r[0];
   assign bus.a01       = elem_r[1];
   assign bus.a10       = elem_r[2];
   assign bus.a11       = elem_r[3];
   assign bus.b00       = elem_r[4];
   assign bus.b01       = elem_r[5];
   assign bus.b10       = elem_r[6];
   assign bus.b11       = elem_r[7];

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Randomized self-checking bench for matrix_operand_loader against a frame-level
// reference model (expected op, elements and handshake count).
module tb_matrix_operand_loader;

   localparam int TB_TIMEOUT = 4;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;

   matrix_operand_loader_if bus ();

   matrix_operand_loader #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [7:0] cur_e [0:7];
   logic [2:0] exp_op;
   int         exp_cnt;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit op_ok(input logic [7:0] b);
`ifdef MATLOAD_OPCHECK_EN
      return (b[2:0] == 3'b001) || (b[2:0] == 3'b010) || (b[2:0] == 3'b100);
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [63:0] dut_elems();
      return {bus.a00, bus.a01, bus.a10, bus.a11, bus.b00, bus.b01, bus.b10, bus.b11};
   endfunction

   function automatic logic [63:0] exp_elems();
      return {cur_e[0], cur_e[1], cur_e[2], cur_e[3], cur_e[4], cur_e[5], cur_e[6], cur_e[7]};
   endfunction

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [7:0] b);
      int w;
      w = 0;
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (bus.in_ready !== 1'b1) chk("push_wait", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_op(input logic [7:0] ob);
      push(ob);
      if (op_ok(ob)) begin
         exp_op = ob[2:0];
         chk("op_err_low", 64'(bus.err), 64'd0);
      end else begin
         chk("op_err_pulse", 64'(bus.err), 64'd1);
      end
      chk("op_value", 64'(bus.op), 64'(exp_op));
   endtask

   task automatic send_elems(input bit gaps, input int n);
      for (int i = 0; i < n; i++) begin
         if (gaps) cycles($urandom_range(0, TB_TIMEOUT - 1));
         push(cur_e[i]);
      end
   endtask

   task automatic check_hold(input string tag);
      chk({tag, "_mat_valid"}, 64'(bus.mat_valid), 64'd1);
      chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
      chk({tag, "_elems"}, dut_elems(), exp_elems());
      chk({tag, "_op"}, 64'(bus.op), 64'(exp_op));
   endtask

   task automatic release_hold();
      bus.mat_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.mat_ready = 1'b0;
      exp_cnt = (exp_cnt + 1) % 256;
      chk("rel_mat_valid", 64'(bus.mat_valid), 64'd0);
      chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rel_frame_cnt", 64'(bus.frame_cnt), 64'(exp_cnt));
   endtask

   task automatic full_frame(input logic [7:0] ob, input bit gaps);
      logic [7:0] nb;
      for (int i = 0; i < 8; i++) cur_e[i] = 8'($urandom);
      send_op(ob);
      if (!op_ok(ob)) begin
         nb = 8'($urandom);
         nb[2:0] = 3'b010;
         send_op(nb);
      end
      send_elems(gaps, 8);
      check_hold("frame");
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_elems"}, dut_elems(), 64'd0);
      chk({tag, "_op"}, 64'(bus.op), 64'd0);
      chk({tag, "_mat_valid"}, 64'(bus.mat_valid), 64'd0);
      chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
      chk({tag, "_err"}, 64'(bus.err), 64'd0);
      chk({tag, "_frame_cnt"}, 64'(bus.frame_cnt), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit err_seen;
      n_chk = 0;
      n_pass = 0;
      exp_op = 3'd0;
      exp_cnt = 0;
      rst_n = 1'b0;
      bus.in_data = 8'd0;
      bus.in_valid = 1'b0;
      bus.mat_ready = 1'b0;
      #23;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

      // Directed back-to-back frame, then a long hold with mat_ready low
      for (int i = 0; i < 8; i++) cur_e[i] = 8'(i + 1);
      send_op(8'h01);
      send_elems(1'b0, 8);
      check_hold("first");
      err_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycles(1);
         if (bus.err === 1'b1) err_seen = 1'b1;
      end
      check_hold("held20");
      chk("held20_err", 64'(err_seen), 64'd0);
      release_hold();
      full_frame(8'h04, 1'b0);
      chk("op_mult", 64'(bus.op), 64'd4);
      release_hold();

      // Idle timeout after op plus three elements
      for (int i = 0; i < 8; i++) cur_e[i] = 8'($urandom);
      send_op(8'hF9);
      send_elems(1'b0, 3);
      for (int k = 1; k <= TB_TIMEOUT; k++) begin
         cycles(1);
         chk($sformatf("to_err_%0d", k), 64'(bus.err), (k == TB_TIMEOUT) ? 64'd1 : 64'd0);
      end
      cycles(1);
      chk("to_err_clear", 64'(bus.err), 64'd0);
      chk("to_in_ready", 64'(bus.in_ready), 64'd1);
      chk("to_mat_valid", 64'(bus.mat_valid), 64'd0);
      chk("to_frame_cnt", 64'(bus.frame_cnt), 64'(exp_cnt));
      full_frame(8'h02, 1'b1);
      release_hold();

      // Non-one-hot op byte
      full_frame(8'h03, 1'b0);
      release_hold();

      // Reset in the middle of a frame
      for (int i = 0; i < 8; i++) cur_e[i] = 8'($urandom);
      send_op(8'h01);
      send_elems(1'b0, 5);
      rst_n = 1'b0;
      #2;
      exp_cnt = 0;
      exp_op = 3'd0;
      check_reset_outputs("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("midreset_in_ready", 64'(bus.in_ready), 64'd1);
      full_frame(8'h01, 1'b1);
      release_hold();

      // Random frames through the frame counter wrap
      exp_cnt = 0;
      rst_n = 1'b0;
      #2;
      exp_op = 3'd0;
      @(negedge clk);
      rst_n = 1'b1;
      cycles(1);
      for (int f = 0; f < 256; f++) begin
         full_frame(8'($urandom), 1'($urandom));
         cycles($urandom_range(0, 2));
         chk("hold_stable", dut_elems(), exp_elems());
         release_hold();
      end
      chk("wrap_zero", 64'(bus.frame_cnt), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
